// File: rtl/rgb_arbiter.sv
// Two-requester round-robin front end for a colour lookup memory.
// Grants are combinational; a {valid, id} tag shift register returns results in grant order.
module rgb_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [2:0]  colour0,
  input  logic        req1,
  input  logic [2:0]  colour1,
  output logic        ack0,
  output logic        ack1,
  output logic        mem_en,
  output logic [2:0]  mem_addr,
  input  logic [23:0] mem_rdata,
  output logic [23:0] rgb_out,
  output logic        valid0,
  output logic        valid1
);

  typedef enum logic {
    LAST_0 = 1'b0,
    LAST_1 = 1'b1
  } last_e;

  last_e         r_last;
  logic [LATENCY:0] r_tag_v;
  logic [LATENCY:0] r_tag_id;
  logic [23:0]   r_rgb;

  logic          w_gnt0;
  logic          w_gnt1;

  // On a tie the requester that did not win most recently is served.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        if (r_last == LAST_1) w_gnt0 = 1'b1;
        else                  w_gnt1 = 1'b1;
      end else if (req0) begin
        w_gnt0 = 1'b1;
      end else if (req1) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    ack0     = w_gnt0;
    ack1     = w_gnt1;
    mem_en   = w_gnt0 | w_gnt1;
    mem_addr = '0;
    if (w_gnt0)      mem_addr = colour0;
    else if (w_gnt1) mem_addr = colour1;
  end

  // Stage LATENCY-1 lines up with mem_rdata; stage LATENCY drives the valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last   <= LAST_1;
      r_tag_v  <= '0;
      r_tag_id <= '0;
      r_rgb    <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[LATENCY-1:0], mem_en};
      r_tag_id <= {r_tag_id[LATENCY-1:0], w_gnt1};
      if (mem_en) r_last <= w_gnt1 ? LAST_1 : LAST_0;
      if (r_tag_v[LATENCY-1]) r_rgb <= mem_rdata;
    end
  end

  // Valid is masked during reset so a result already in the last stage is dropped too.
  assign rgb_out = r_rgb;
  assign valid0  = r_tag_v[LATENCY] & ~r_tag_id[LATENCY] & ~rst;
  assign valid1  = r_tag_v[LATENCY] &  r_tag_id[LATENCY] & ~rst;

endmodule

// File: tb/tb_rgb_arbiter.sv
// Scoreboard bench: two DUTs (LATENCY 1 and 2) share stimulus; each has its own memory model.
module tb_rgb_arbiter;

  typedef struct {
    int unsigned due;
    bit          id;
    logic [23:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [2:0]  colour0, colour1;

  logic        ack0_a, ack1_a, en_a, v0_a, v1_a;
  logic [2:0]  addr_a;
  logic [23:0] rd_a, rgb_a;
  logic        ack0_b, ack1_b, en_b, v0_b, v1_b;
  logic [2:0]  addr_b;
  logic [23:0] rd_b, rgb_b;

  logic [23:0] img [8];
  logic [23:0] mp_a, mp_b0, mp_b1;
  logic [23:0] hold [2];

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned cyc = 0;
  int          last_gnt = 1;
  int          checks = 0;
  int          errors = 0;
  bit          prev_rst = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgb_arbiter #(.LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req0(req0), .colour0(colour0), .req1(req1), .colour1(colour1),
    .ack0(ack0_a), .ack1(ack1_a), .mem_en(en_a), .mem_addr(addr_a), .mem_rdata(rd_a),
    .rgb_out(rgb_a), .valid0(v0_a), .valid1(v1_a)
  );

  rgb_arbiter #(.LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .colour0(colour0), .req1(req1), .colour1(colour1),
    .ack0(ack0_b), .ack1(ack1_b), .mem_en(en_b), .mem_addr(addr_b), .mem_rdata(rd_b),
    .rgb_out(rgb_b), .valid0(v0_b), .valid1(v1_b)
  );

  // Memory returns garbage when not enabled, so stray sampling shows up as a wrong code.
  always @(posedge clk) begin
    mp_a  <= en_a ? img[addr_a] : 24'($urandom);
    mp_b0 <= en_b ? img[addr_b] : 24'($urandom);
    mp_b1 <= mp_b0;
  end
  assign rd_a = mp_a;
  assign rd_b = mp_b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_lane(input int lane, input logic v0, input logic v1, input logic [23:0] rgb);
    exp_t e;
    bit   have;
    string tag;
    tag  = $sformatf("lane%0d", lane);
    have = (lane == 0) ? (qa.size() > 0) : (qb.size() > 0);
    if (have) e = (lane == 0) ? qa[0] : qb[0];
    if (rst) begin
      chk({tag, "_valid_in_reset"}, {v0, v1}, 2'b00);
    end else if (v0 || v1) begin
      chk({tag, "_valid_exclusive"}, v0 & v1, 1'b0);
      if (!have) begin
        chk({tag, "_unexpected_valid"}, {v0, v1}, 2'b00);
      end else begin
        if (lane == 0) void'(qa.pop_front()); else void'(qb.pop_front());
        chk({tag, "_valid_cycle"}, 64'(cyc), 64'(e.due));
        chk({tag, "_valid_id"}, {v0, v1}, e.id ? 2'b01 : 2'b10);
        chk({tag, "_rgb"}, rgb, e.rgb);
        hold[lane] = e.rgb;
      end
    end else begin
      if (have && e.due <= cyc) begin
        chk({tag, "_missing_valid"}, 1'b0, 1'b1);
        if (lane == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      end
      chk({tag, "_rgb_hold"}, rgb, hold[lane]);
    end
  endtask

  always @(negedge clk) begin
    if (prev_rst) begin
      hold[0] = '0;
      hold[1] = '0;
    end
    mon_lane(0, v0_a, v1_a, rgb_a);
    mon_lane(1, v0_b, v1_b, rgb_b);
    prev_rst = rst;
  end

  task automatic step(input bit r, input bit q0, input logic [2:0] k0,
                      input bit q1, input logic [2:0] k1, output bit a0, output bit a1);
    int         g;
    exp_t       e;
    logic [5:0] ev;
    @(posedge clk);
    #1;
    rst = r; req0 = q0; colour0 = k0; req1 = q1; colour1 = k1;
    if (r) begin
      qa.delete();
      qb.delete();
    end
    @(negedge clk);
    g = -1;
    if (!r) begin
      if (q0 && q1) g = (last_gnt == 1) ? 0 : 1;
      else if (q0)  g = 0;
      else if (q1)  g = 1;
    end
    ev = (g == 0) ? {3'b101, k0} : (g == 1) ? {3'b011, k1} : 6'b0;
    chk("grant_lat1", {ack0_a, ack1_a, en_a, addr_a}, ev);
    chk("grant_lat2", {ack0_b, ack1_b, en_b, addr_b}, ev);
    if (g >= 0) begin
      last_gnt = g;
      e.id  = (g == 1);
      e.rgb = img[(g == 0) ? k0 : k1];
      e.due = cyc + 2;
      qa.push_back(e);
      e.due = cyc + 3;
      qb.push_back(e);
    end
    if (r) last_gnt = 1;
    a0 = (g == 0);
    a1 = (g == 1);
  endtask

  initial begin
    bit a0, a1, r, q0, q1, h0, h1;
    logic [2:0] k0, k1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; colour0 = '0; colour1 = '0;
    for (int i = 0; i < 8; i++) img[i] = 24'($urandom);
    img[2] = 24'h00FF00;

    step(1, 0, 0, 0, 0, a0, a1);
    step(1, 1, 3, 1, 5, a0, a1);
    // single requester 0 lookup of entry 2
    step(0, 1, 3'd2, 0, 0, a0, a1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, a0, a1);
    // both requesters held: strict alternation from a fresh reset
    step(1, 0, 0, 0, 0, a0, a1);
    for (int i = 0; i < 6; i++) step(0, 1, 3'd1, 1, 3'd4, a0, a1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, a0, a1);
    // requester 1 alone, colour stepping
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3'(i), a0, a1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, a0, a1);
    // grant then reset: the lookup is discarded and req0 wins the next tie
    step(0, 1, 3'd5, 0, 0, a0, a1);
    step(1, 0, 0, 0, 0, a0, a1);
    step(0, 1, 3'd3, 1, 3'd6, a0, a1);
    step(0, 0, 0, 1, 3'd6, a0, a1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, a0, a1);

    h0 = 0; h1 = 0; q0 = 0; q1 = 0; k0 = '0; k1 = '0;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) == 0);
      if (!h0) begin q0 = ($urandom_range(0, 99) < 65); k0 = 3'($urandom); end
      if (!h1) begin q1 = ($urandom_range(0, 99) < 65); k1 = 3'($urandom); end
      step(r, q0, k0, q1, k1, a0, a1);
      h0 = q0 && !a0;
      h1 = q1 && !a1;
    end

    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, a0, a1);
    chk("drain_lat1", 64'(qa.size()), 64'd0);
    chk("drain_lat2", 64'(qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
